// File: rtl/pa_dtcm_pkg.sv
// Shared encodings for the DTCM SRAM controller: access sizes, FSM states, lane count.
package pa_dtcm_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_ILL  = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pa_dtcm_wen_gen.sv
// Combinational store-lane decoder: size + byte offset + right-aligned data ->
// legality, per-bit active-low write enables and lane-replicated write data.
module pa_dtcm_wen_gen
    import pa_dtcm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        legal,
    output logic [31:0] wen,
    output logic [31:0] d
);

    logic [LANES-1:0] lanes;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        legal = 1'b0;
        lanes = '0;
        d     = wdata;
        wen   = '1;
        case (size_e'(size))
            SIZE_BYTE: begin
                legal = 1'b1;
                lanes = 4'b0001 << addr_lo;
                d     = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                legal = !addr_lo[0];
                lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
                d     = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                legal = (addr_lo == 2'b00);
                lanes = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
        for (int i = 0; i < LANES; i++) begin
            wen[8*i +: 8] = lanes[i] ? 8'h00 : 8'hFF;
        end
    end

endmodule

// File: rtl/pa_dtcm_sram_ctrl.sv
// LSU-side controller for the 8192x32 single-port DTCM macro. Defining
// PA_DTCM_SRAM_INIT_EN adds a post-reset zero-fill sweep of the whole array.
module pa_dtcm_sram_ctrl
    import pa_dtcm_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_load_q, rsp_load_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] init_addr;

    logic                  gen_legal;
    logic [DATA_WIDTH-1:0] gen_wen, gen_d;
    logic                  init_active, run, stall, accept, access;

`ifdef PA_DTCM_SRAM_INIT_EN
    localparam state_e RESET_STATE = ST_INIT;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    assign init_addr = cnt_q;
`else
    localparam state_e RESET_STATE = ST_RUN;
    assign init_addr = '0;
`endif

    pa_dtcm_wen_gen u_wen_gen (
        .size    (req_size),
        .addr_lo (req_addr[1:0]),
        .wdata   (req_wdata),
        .legal   (gen_legal),
        .wen     (gen_wen),
        .d       (gen_d)
    );

    // Gating with cpurst_b keeps the strobes idle and req_rdy low throughout reset.
    assign init_active = cpurst_b && (state_q == ST_INIT);
    assign run         = cpurst_b && (state_q == ST_RUN);
    assign init_done   = run;
    assign stall       = rsp_vld_q && !rsp_rdy;
    assign req_rdy     = run && !stall;
    assign accept      = req_vld && req_rdy;
    assign access      = accept && gen_legal;

    always_comb begin
        state_d = state_q;
`ifdef PA_DTCM_SRAM_INIT_EN
        cnt_d = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (&cnt_q) state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
    end

    // Address and data hold their last value on idle cycles to limit toggling.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_q;
        sram_d    = d_q;
        if (init_active) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_addr;
            sram_d    = '0;
        end else if (access) begin
            sram_cen = 1'b0;
            sram_a   = req_addr[ADDR_WIDTH+1:2];
            if (req_write) begin
                sram_gwen = 1'b0;
                sram_wen  = gen_wen;
                sram_d    = gen_d;
            end
        end
        a_d = sram_a;
        d_d = sram_d;
    end

    always_comb begin
        rsp_rdata = '0;
        if (rsp_vld_q) begin
            if (hold_vld_q)      rsp_rdata = hold_q;
            else if (rsp_load_q) rsp_rdata = sram_q;
        end
    end

    always_comb begin
        rsp_vld_d  = rsp_vld_q;
        rsp_err_d  = rsp_err_q;
        rsp_load_d = rsp_load_q;
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (accept) begin
            rsp_vld_d  = 1'b1;
            rsp_err_d  = !gen_legal;
            rsp_load_d = gen_legal && !req_write;
            hold_vld_d = 1'b0;
        end else if (rsp_vld_q && rsp_rdy) begin
            rsp_vld_d  = 1'b0;
            rsp_err_d  = 1'b0;
            rsp_load_d = 1'b0;
            hold_vld_d = 1'b0;
        end else if (stall && !hold_vld_q) begin
            // Q is only guaranteed the cycle after the read, so freeze it at the first stall edge.
            hold_vld_d = 1'b1;
            hold_d     = rsp_rdata;
        end
    end

    assign rsp_vld = rsp_vld_q;
    assign rsp_err = rsp_err_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= RESET_STATE;
            a_q        <= '0;
            d_q        <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            d_q        <= d_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_load_q <= rsp_load_d;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end

`ifdef PA_DTCM_SRAM_INIT_EN
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_pa_dtcm_sram_ctrl.sv
// Directed self-checking bench for pa_dtcm_sram_ctrl with a behavioural 8192x32 macro model.
// Exercises the zero-fill sweep only when PA_DTCM_SRAM_INIT_EN is defined.
module tb_pa_dtcm_sram_ctrl;

    localparam int AW = 13;
`ifdef PA_DTCM_SRAM_INIT_EN
    localparam int EXP_INIT = 8192;
`else
    localparam int EXP_INIT = 0;
`endif

    logic          cpuclk = 1'b0;
    logic          cpurst_b = 1'b0;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'd2;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [31:0]   sram_wen;
    logic [31:0]   sram_d;
    logic [31:0]   sram_q = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    always #5 cpuclk = ~cpuclk;

    // Macro model: Q is garbage on any cycle without a read, so a missing hold register shows up.
    always @(posedge cpuclk) begin
        if (!sram_cen && sram_gwen) sram_q <= mem[sram_a];
        else                        sram_q <= 32'hBAD0_BAD0;
        if (!sram_cen && !sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
    end

    pa_dtcm_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .cpuclk    (cpuclk),
        .cpurst_b  (cpurst_b),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done),
        .sram_a    (sram_a),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    task automatic tick();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 20000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n !== EXP_INIT) begin n_err++; $display("FAIL %s: init cycles got %0d want %0d", name, n, EXP_INIT); end
    endtask

    task automatic test_reset();
        cpurst_b = 1'b0;
        req_vld  = 1'b0;
        rsp_rdy  = 1'b1;
        repeat (2) @(posedge cpuclk);
        #1;
        n_cmp++;
        if ({rsp_vld, rsp_err, req_rdy, sram_cen, sram_gwen} !== 5'b00011) begin
            n_err++; $display("FAIL rst_ctl: got vld/err/rdy/cen/gwen %b want 00011", {rsp_vld, rsp_err, req_rdy, sram_cen, sram_gwen});
        end
        n_cmp++;
        if (sram_wen !== 32'hFFFF_FFFF || sram_a !== '0 || sram_d !== '0 || rsp_rdata !== '0) begin
            n_err++; $display("FAIL rst_bus: got wen %h a %h d %h rdata %h want ffffffff 0 0 0", sram_wen, sram_a, sram_d, rsp_rdata);
        end
        cpurst_b = 1'b1;
        #1;
`ifdef PA_DTCM_SRAM_INIT_EN
        n_cmp++;
        if ({init_done, req_rdy, sram_cen, sram_a} !== {3'b000, 13'd0}) begin
            n_err++; $display("FAIL init_start: got done/rdy/cen %b a %h want 000 0", {init_done, req_rdy, sram_cen}, sram_a);
        end
`endif
        wait_init("init_len");
        n_cmp++;
        if (req_rdy !== 1'b1) begin n_err++; $display("FAIL run_rdy: got %b want 1", req_rdy); end
    endtask

    task automatic test_init_sweep();
        int n = 0;
        req_vld = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 15'h7FFC;
        #1;
        n_cmp++;
        if (sram_cen !== 1'b0 || sram_a !== 13'h1FFF) begin n_err++; $display("FAIL ld_top_acc: got cen %b a %h want 0 1fff", sram_cen, sram_a); end
        tick();
        req_vld = 1'b0;
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL ld_top: got vld %b rdata %h want 1 0", rsp_vld, rsp_rdata); end
        cpurst_b = 1'b0;
        #1;
        cpurst_b = 1'b1;
        #1;
        while (!(sram_a == 13'd100 && !sram_cen) && n < 500) begin
            tick();
            n++;
        end
        n_cmp++;
        if (sram_a !== 13'd100) begin n_err++; $display("FAIL sweep_100: got a %0d want 100", sram_a); end
        cpurst_b = 1'b0;
        #1;
        n_cmp++;
        if (sram_a !== 13'd0 || sram_cen !== 1'b1 || rsp_vld !== 1'b0) begin
            n_err++; $display("FAIL sweep_rst: got a %0d cen %b vld %b want 0 1 0", sram_a, sram_cen, rsp_vld);
        end
        tick();
        cpurst_b = 1'b1;
        #1;
        n_cmp++;
        if (sram_a !== 13'd0 || sram_cen !== 1'b0 || sram_wen !== 32'h0) begin
            n_err++; $display("FAIL sweep_restart: got a %0d cen %b wen %h want 0 0 0", sram_a, sram_cen, sram_wen);
        end
        wait_init("init_len2");
    endtask

    task automatic test_word_store_load();
        rsp_rdy = 1'b1;
        req_vld = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 15'h0010; req_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if ({req_rdy, sram_cen, sram_gwen} !== 3'b100 || sram_wen !== 32'h0 || sram_a !== 13'h4 || sram_d !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL st_word: got rdy/cen/gwen %b wen %h a %h d %h", {req_rdy, sram_cen, sram_gwen}, sram_wen, sram_a, sram_d);
        end
        tick();
        n_cmp++;
        if ({rsp_vld, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL st_rsp: got vld/err %b rdata %h want 10 0", {rsp_vld, rsp_err}, rsp_rdata);
        end
        req_write = 1'b0;
        #1;
        n_cmp++;
        if ({sram_cen, sram_gwen} !== 2'b01 || sram_wen !== 32'hFFFF_FFFF || sram_a !== 13'h4) begin
            n_err++; $display("FAIL ld_word: got cen/gwen %b wen %h a %h", {sram_cen, sram_gwen}, sram_wen, sram_a);
        end
        tick();
        req_vld = 1'b0;
        n_cmp++;
        if ({rsp_vld, rsp_err} !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL ld_rsp: got vld/err %b rdata %h want 10 deadbeef", {rsp_vld, rsp_err}, rsp_rdata);
        end
        tick();
        n_cmp++;
        if (rsp_vld !== 1'b0 || sram_cen !== 1'b1) begin n_err++; $display("FAIL idle: got vld %b cen %b want 0 1", rsp_vld, sram_cen); end
    endtask

    task automatic test_byte_half();
        req_vld = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 15'h0010; req_wdata = 32'h1122_3344;
        tick();
        req_size = 2'd0; req_addr = 15'h0013; req_wdata = 32'h1234_56A5;
        #1;
        n_cmp++;
        if (sram_wen !== 32'h00FF_FFFF || sram_d !== 32'hA5A5_A5A5 || sram_a !== 13'h4) begin
            n_err++; $display("FAIL st_byte: got wen %h d %h a %h want 00ffffff a5a5a5a5 4", sram_wen, sram_d, sram_a);
        end
        tick();
        req_write = 1'b0; req_size = 2'd2; req_addr = 15'h0010;
        tick();
        n_cmp++;
        if (rsp_rdata !== 32'hA522_3344) begin n_err++; $display("FAIL ld_byte: got %h want a5223344", rsp_rdata); end
        req_write = 1'b1; req_size = 2'd1; req_addr = 15'h0012; req_wdata = 32'h9999_BEEF;
        #1;
        n_cmp++;
        if (sram_wen !== 32'h0000_FFFF || sram_d !== 32'hBEEF_BEEF) begin
            n_err++; $display("FAIL st_half: got wen %h d %h want 0000ffff beefbeef", sram_wen, sram_d);
        end
        tick();
        req_write = 1'b0; req_size = 2'd2; req_addr = 15'h0010;
        tick();
        req_vld = 1'b0;
        n_cmp++;
        if (rsp_rdata !== 32'hBEEF_3344) begin n_err++; $display("FAIL ld_half: got %h want beef3344", rsp_rdata); end
        tick();
    endtask

    task automatic test_illegal();
        req_vld = 1'b1; req_write = 1'b0; req_size = 2'd1; req_addr = 15'h0001;
        #1;
        n_cmp++;
        if ({req_rdy, sram_cen, sram_gwen} !== 3'b111) begin n_err++; $display("FAIL ill_half_acc: got rdy/cen/gwen %b want 111", {req_rdy, sram_cen, sram_gwen}); end
        tick();
        n_cmp++;
        if ({rsp_vld, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL ill_half_rsp: got vld/err %b rdata %h want 11 0", {rsp_vld, rsp_err}, rsp_rdata);
        end
        req_write = 1'b1; req_size = 2'd2; req_addr = 15'h0006; req_wdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if ({sram_cen, sram_gwen} !== 2'b11) begin n_err++; $display("FAIL ill_word_acc: got cen/gwen %b want 11", {sram_cen, sram_gwen}); end
        tick();
        req_vld = 1'b0;
        n_cmp++;
        if ({rsp_vld, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL ill_word_rsp: got vld/err %b rdata %h want 11 0", {rsp_vld, rsp_err}, rsp_rdata);
        end
        req_vld = 1'b1; req_write = 1'b0; req_size = 2'd3; req_addr = 15'h0010;
        tick();
        req_vld = 1'b0;
        n_cmp++;
        if (rsp_err !== 1'b1) begin n_err++; $display("FAIL ill_size: got err %b want 1", rsp_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        rsp_rdy = 1'b1; req_vld = 1'b1; req_write = 1'b1; req_size = 2'd2;
        for (int i = 0; i < 8; i++) begin
            req_addr = 15'h0100 + 15'(4 * i);
            req_wdata = 32'hC0DE_0000 + 32'(i);
            tick();
            n_cmp++;
            if ({rsp_vld, rsp_err} !== 2'b10) begin n_err++; $display("FAIL b2b_st%0d: got vld/err %b want 10", i, {rsp_vld, rsp_err}); end
        end
        req_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 15'h0100 + 15'(4 * i);
            #1;
            n_cmp++;
            if (sram_cen !== 1'b0 || sram_a !== 13'h40 + 13'(i)) begin
                n_err++; $display("FAIL b2b_acc%0d: got cen %b a %h want 0 %h", i, sram_cen, sram_a, 13'h40 + 13'(i));
            end
            tick();
            n_cmp++;
            if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hC0DE_0000 + 32'(i)) begin
                n_err++; $display("FAIL b2b_ld%0d: got vld %b rdata %h want 1 %h", i, rsp_vld, rsp_rdata, 32'hC0DE_0000 + 32'(i));
            end
            if (i == 3) begin
                rsp_rdy = 1'b0;
                req_addr = 15'h0110;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    n_cmp++;
                    if (req_rdy !== 1'b0 || sram_cen !== 1'b1) begin
                        n_err++; $display("FAIL stall_acc%0d: got rdy %b cen %b want 0 1", k, req_rdy, sram_cen);
                    end
                    tick();
                    n_cmp++;
                    if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hC0DE_0003) begin
                        n_err++; $display("FAIL stall_data%0d: got vld %b rdata %h want 1 c0de0003", k, rsp_vld, rsp_rdata);
                    end
                end
                rsp_rdy = 1'b1;
            end
        end
        req_vld = 1'b0;
        tick();
        n_cmp++;
        if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got vld %b want 0", rsp_vld); end
    endtask

    task automatic test_reset_stall();
        rsp_rdy = 1'b1; req_vld = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 15'h0010;
        tick();
        req_vld = 1'b0; rsp_rdy = 1'b0;
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hBEEF_3344) begin
            n_err++; $display("FAIL rs_ld: got vld %b rdata %h want 1 beef3344", rsp_vld, rsp_rdata);
        end
        tick();
        cpurst_b = 1'b0;
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b0 || sram_cen !== 1'b1) begin n_err++; $display("FAIL rs_drop: got vld %b cen %b want 0 1", rsp_vld, sram_cen); end
        tick();
        cpurst_b = 1'b1;
        rsp_rdy = 1'b1;
        #1;
        wait_init("init_len3");
        repeat (3) begin
            tick();
            n_cmp++;
            if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL rs_stale: got vld %b want 0", rsp_vld); end
        end
    endtask

    initial begin
        test_reset();
`ifdef PA_DTCM_SRAM_INIT_EN
        test_init_sweep();
`endif
        test_word_store_load();
        test_byte_half();
        test_illegal();
        test_back_to_back();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
